// File: rtl/booth_mul_issuer.sv
// booth_mul_issuer: initiator for a start/done/busy multiplier core.
// Accepts operand triples on a valid/ready stream, issues each one to the
// core as a single-cycle start pulse, waits for done (with timeout) and
// returns products in order through a small result FIFO.
module booth_mul_issuer #(
  parameter int WIDTH          = 16,
  parameter int RESULT_DEPTH   = 2,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [1:0]           in_mode,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_multiplicand,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic [1:0]           mul_sign_mode,
  input  logic [2*WIDTH-1:0]   mul_product,
  input  logic                 mul_done,
  input  logic                 mul_busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 out_err,
  output logic                 timeout_flag
);

  localparam int PW    = 2 * WIDTH;
  localparam int PTR_W = $clog2(RESULT_DEPTH);
  localparam int CNT_W = $clog2(RESULT_DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IDLE = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;

  // Result storage; the head is mirrored into registered output flops.
  logic [PW-1:0]     mem_prod [RESULT_DEPTH];
  logic              mem_err  [RESULT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next, remain;

  logic              in_ready_reg, in_ready_next;
  logic              out_valid_reg, out_valid_next;
  logic [PW-1:0]     out_product_reg, out_product_next;
  logic              out_err_reg, out_err_next;

  logic              accept;
  logic              push;
  logic              push_err;
  logic [PW-1:0]     push_prod;
  logic              pop;

  assign in_ready     = in_ready_reg;
  assign out_valid    = out_valid_reg;
  assign out_product  = out_product_reg;
  assign out_err      = out_err_reg;
  assign mul_start    = (state_reg == START);
  assign pop          = out_valid_reg && out_ready;

  // Next-state, timeout counting and FIFO push generation.
  always_comb begin
    state_next  = state_reg;
    to_cnt_next = to_cnt_reg;
    accept      = 1'b0;
    push        = 1'b0;
    push_err    = 1'b0;
    push_prod   = '0;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready_reg) begin
          accept     = 1'b1;
          state_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!mul_busy) begin
          state_next = START;
        end
      end
      START: begin
        state_next  = WAIT_DONE;
        to_cnt_next = '0;
      end
      WAIT_DONE: begin
        if (mul_done) begin
          push       = 1'b1;
          push_prod  = mul_product;
          state_next = IDLE;
        end else if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Abort: an error entry keeps result ordering intact.
          push       = 1'b1;
          push_err   = 1'b1;
          state_next = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO occupancy, head selection and input-side readiness.
  always_comb begin
    count_next       = count_reg + CNT_W'(push) - CNT_W'(pop);
    remain           = count_reg - CNT_W'(pop);
    rd_ptr_next      = rd_ptr_reg + PTR_W'(pop);
    out_valid_next   = (count_next != '0);
    out_product_next = out_product_reg;
    out_err_next     = out_err_reg;
    if (count_next != '0) begin
      if (remain == '0) begin
        // Entry being pushed becomes the head straight away.
        out_product_next = push_prod;
        out_err_next     = push_err;
      end else begin
        out_product_next = mem_prod[rd_ptr_next];
        out_err_next     = mem_err[rd_ptr_next];
      end
    end
    // Slot is reserved at accept, so a later push never overflows.
    in_ready_next = (state_next == IDLE) &&
                    (count_next < CNT_W'(RESULT_DEPTH));
  end

  // Result storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_prod[wr_ptr_reg] <= push_prod;
      mem_err[wr_ptr_reg]  <= push_err;
    end
  end

  // Control state, operand latches, FIFO pointers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      to_cnt_reg       <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      in_ready_reg     <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_product_reg  <= '0;
      out_err_reg      <= 1'b0;
      timeout_flag     <= 1'b0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      mul_sign_mode    <= '0;
    end else begin
      state_reg       <= state_next;
      to_cnt_reg      <= to_cnt_next;
      count_reg       <= count_next;
      rd_ptr_reg      <= rd_ptr_next;
      in_ready_reg    <= in_ready_next;
      out_valid_reg   <= out_valid_next;
      out_product_reg <= out_product_next;
      out_err_reg     <= out_err_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (push && push_err) begin
        timeout_flag <= 1'b1;
      end
      if (accept) begin
        mul_multiplicand <= in_a;
        mul_multiplier   <= in_b;
        mul_sign_mode    <= in_mode;
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_issuer.sv
// Testbench for booth_mul_issuer: behavioural multiplier core model plus
// an in-order expected-result queue built from plain arithmetic.
module tb_booth_mul_issuer;

  localparam int W  = 16;
  localparam int D  = 2;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_a = '0;
  logic [W-1:0]    in_b = '0;
  logic [1:0]      in_mode = '0;
  logic            mul_start;
  logic [W-1:0]    mul_multiplicand;
  logic [W-1:0]    mul_multiplier;
  logic [1:0]      mul_sign_mode;
  logic [2*W-1:0]  mul_product = '0;
  logic            mul_done = 1'b0;
  logic            mul_busy;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*W-1:0]  out_product;
  logic            out_err;
  logic            timeout_flag;

  always #5 clk = ~clk;

  booth_mul_issuer #(.WIDTH(W), .RESULT_DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier), .mul_sign_mode(mul_sign_mode),
    .mul_product(mul_product), .mul_done(mul_done), .mul_busy(mul_busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_err(out_err),
    .timeout_flag(timeout_flag)
  );

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  logic [31:0] last_prod;

  // Product as the core would compute it: sign-extend per mode, multiply.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] m);
    longint sa, sb;
    sa = m[1] ? longint'($signed(a)) : longint'(a);
    sb = m[0] ? longint'($signed(b)) : longint'(b);
    return 32'(sa * sb);
  endfunction

  // Multiplier core model: done 'lat'+1 cycles after the start is seen.
  int   lat = 2;
  bit   no_done = 1'b0;
  bit   force_busy = 1'b0;
  logic m_active = 1'b0;
  int   m_cnt = 0;
  logic [31:0] m_prod = '0;
  assign mul_busy = m_active | force_busy;

  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (m_active) begin
      if (m_cnt == 0) begin
        m_active <= 1'b0;
        if (!no_done) begin
          mul_done    <= 1'b1;
          mul_product <= m_prod;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (mul_start) begin
      m_active <= 1'b1;
      m_cnt    <= lat;
      m_prod   <= ref_mul(mul_multiplicand, mul_multiplier, mul_sign_mode);
    end
  end

  // Start pulse monitor: number of pulses and longest high run.
  int start_pulses = 0;
  int start_run = 0;
  int max_run = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      start_run <= start_run + 1;
      if (start_run == 0) start_pulses <= start_pulses + 1;
      if (start_run + 1 > max_run) max_run <= start_run + 1;
    end else begin
      start_run <= 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 normal result expected, 1 timeout entry expected, 2 abandoned
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] m, input int kind);
    int n = 0;
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_wait_in_ready", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (kind == 0) exp_q.push_back({1'b0, ref_mul(a, b, m)});
      else if (kind == 1) exp_q.push_back({1'b1, 32'h0});
      #1 in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic recv(input string tag);
    int n = 0;
    logic [32:0] e;
    out_ready = 1'b1;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    if (out_valid) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
      chk({tag, "_product"}, out_product, e[31:0]);
      chk({tag, "_err"}, out_err, e[32]);
      last_prod = out_product;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
    end else begin
      out_ready = 1'b0;
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!mul_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_mul_start", mul_start, 1);
  endtask

  initial begin
    int p0;
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_multiplicand", mul_multiplicand, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_product", out_product, 0);
    chk("rst_timeout_flag", timeout_flag, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Test 1: signed x signed
    p0 = start_pulses;
    lat = 3;
    send(16'h7FFF, 16'h8000, 2'b11, 0);
    recv("t1");
    chk("t1_const", last_prod, 32'hC000_8000);
    chk("t1_pulses", start_pulses - p0, 1);

    // Test 2: two operations, in order
    send(16'hFFFF, 16'hFFFF, 2'b00, 0);
    send(16'hFFFF, 16'h0002, 2'b10, 0);
    recv("t2a");
    chk("t2a_const", last_prod, 32'hFFFE_0001);
    recv("t2b");
    chk("t2b_const", last_prod, 32'hFFFF_FFFE);
    chk("t2_start_width", max_run, 1);

    // Test 3: backpressure with a full result FIFO
    lat = 2;
    send(16'h0003, 16'h0005, 2'b00, 0);
    send(16'hFFFD, 16'h0007, 2'b10, 0);
    fork
      send(16'h1234, 16'hF00F, 2'b01, 0);
      begin
        repeat (12) @(negedge clk);
        chk("t3_in_ready_full", in_ready, 0);
        chk("t3_out_valid_full", out_valid, 1);
        recv("t3a");
        recv("t3b");
        recv("t3c");
      end
    join

    // Test 4: busy gating
    force_busy = 1'b1;
    p0 = start_pulses;
    send(16'h00AA, 16'h0055, 2'b00, 0);
    repeat (10) @(negedge clk);
    chk("t4_no_start_busy", start_pulses - p0, 0);
    force_busy = 1'b0;
    @(negedge clk);
    chk("t4_start_high", mul_start, 1);
    @(negedge clk);
    chk("t4_start_low", mul_start, 0);
    recv("t4");

    // Test 5: timeout after TO cycles in WAIT_DONE
    no_done = 1'b1;
    lat = 1;
    send(16'h0101, 16'h0202, 2'b00, 1);
    wait_start();
    repeat (TO) @(negedge clk);
    chk("t5_not_early", out_valid, 0);
    @(negedge clk);
    chk("t5_valid", out_valid, 1);
    chk("t5_product_zero", out_product, 0);
    chk("t5_err", out_err, 1);
    chk("t5_flag", timeout_flag, 1);
    recv("t5");
    no_done = 1'b0;
    send(16'h0010, 16'h0011, 2'b00, 0);
    recv("t5_next");
    chk("t5_flag_sticky", timeout_flag, 1);

    // Test 6: reset mid-operation, stale done afterwards
    lat = 30;
    send(16'h4321, 16'h1111, 2'b00, 2);
    wait_start();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_flag", timeout_flag, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    n = 0;
    while (!mul_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_stale_done_seen", mul_done, 1);
    repeat (3) @(negedge clk);
    chk("t6_no_push", out_valid, 0);
    lat = 2;
    send(16'h0001, 16'h00FF, 2'b00, 0);
    recv("t6");
    chk("t6_const", last_prod, 32'h0000_00FF);

    // Randomized stream with random consumer backpressure
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          lat = $urandom_range(0, 5);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(16'($urandom), 16'($urandom), 2'($urandom), 0);
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        logic [32:0] e;
        while (got < 12 && cyc < 3000) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
            chk("rnd_product", out_product, e[31:0]);
            chk("rnd_err", out_err, e[32]);
            got++;
          end
          cyc++;
        end
        chk("rnd_count", got, 12);
        @(posedge clk);
        #1 out_ready = 1'b0;
      end
    join
    chk("final_start_width", max_run, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mul_issuer.md
Name: booth_mul_issuer

Overview:
Initiator side of the multiplier start/done/busy interface. Accepts operand triples (a, b, sign_mode) on a valid/ready stream and issues each one to a booth_radix8_multiplier instance as a one-cycle start pulse. It waits for done (with timeout), captures the product, and returns results in order through a small result FIFO with valid/ready output. It sits between a processor-side or DMA-side operand source and the multiplier core, and replaces ad-hoc start/done sequencing in client logic.

Parameters:
WIDTH, 16, operand width; products are 2*WIDTH bits.
RESULT_DEPTH, 2, result FIFO entries; power of two, minimum 2.
TIMEOUT_CYCLES, 2000, cycles in WAIT_DONE before an operation is aborted.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand triple present.
in_ready  output  1  issuer accepts triple this cycle.
in_a  input  WIDTH  multiplicand.
in_b  input  WIDTH  multiplier.
in_mode  input  2  [1]=multiplicand signed, [0]=multiplier signed.
mul_start  output  1  start pulse to multiplier.
mul_multiplicand  output  WIDTH  registered operand to multiplier.
mul_multiplier  output  WIDTH  registered operand to multiplier.
mul_sign_mode  output  2  registered mode to multiplier.
mul_product  input  2*WIDTH  multiplier result; valid in the cycle mul_done=1.
mul_done  input  1  multiplier completion.
mul_busy  input  1  multiplier busy.
out_valid  output  1  result FIFO non-empty.
out_ready  input  1  consumer takes head entry.
out_product  output  2*WIDTH  head result.
out_err  output  1  head entry was a timeout abort.
timeout_flag  output  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. All outputs are 0: in_ready, mul_start, mul_* operand regs, out_valid, out_product, out_err, timeout_flag. FIFO is empty; timeout counter is 0. An operation in flight is abandoned. A late mul_done after reset is ignored because the FSM is in IDLE.
- The FSM has four states: IDLE, WAIT_IDLE, START, WAIT_DONE.
- IDLE:
  - in_ready = 1 when the FIFO count < RESULT_DEPTH. This reserves the slot at accept, so a push can never overflow.
  - On in_valid && in_ready, latch in_a/in_b/in_mode into the mul_* regs and go to WAIT_IDLE.
- WAIT_IDLE: if mul_busy=0, go to START; otherwise hold.
- START:
  - mul_start=1 for exactly this one cycle; go to WAIT_DONE and clear the counter.
  - Operands stay stable from the latch until the next accept.
- WAIT_DONE:
  - mul_done=1: push {mul_product, err=0} into the FIFO and return to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without done, push {0, err=1}, set timeout_flag, and return to IDLE.
  - mul_done is ignored in every state except WAIT_DONE.
- Latency: accept at edge N, then mul_start is high during cycle N+1 (if busy=0) and done is sampled at edge M. The result is visible on out_valid/out_product after edge M. in_ready is high again after edge M if space remains, so the minimum issue spacing is 3 cycles plus the multiplier latency.
- FIFO:
  - In-order, registered outputs. out_product/out_err show the head entry.
  - Pop occurs on out_valid && out_ready.
  - A push and a pop in the same cycle are both honoured, and the count is unchanged.
  - Pointers wrap modulo RESULT_DEPTH.
  - When empty, out_valid=0 and out_product holds its last value.
- No arithmetic is performed here. mul_product is passed through bit-exact; sign interpretation belongs to the core.

Test Plan:
1. After reset, in_a=0x7FFF, in_b=0x8000, in_mode=11 → one mul_start pulse; out_product=0xC0008000, out_err=0.
2. Sequence (0xFFFF,0xFFFF,00) then (0xFFFF,0x0002,10), out_ready=1 → results 0xFFFE0001 then 0xFFFFFFFE, in order; each mul_start is exactly 1 cycle wide.
3. Backpressure: out_ready=0 with 3 triples offered, RESULT_DEPTH=2 → 2 accepted and in_ready=0 afterwards. Raising out_ready → 2 results in order, then the third is accepted and completes.
4. Busy gating: mul_busy=1 for 10 cycles after accept → mul_start stays 0 until the cycle after busy falls, then pulses once.
5. Timeout: model never asserts done, TIMEOUT_CYCLES=16 → exactly 16 cycles after the start pulse, out_valid=1, out_product=0, out_err=1, timeout_flag=1. The next operation completes normally and timeout_flag stays 1.
6. Reset mid-operation: assert rst_n=0 in WAIT_DONE, release, then model asserts a stale mul_done → no push and out_valid=0; a new operation (0x0001,0x00FF,00) returns 0x000000FF.
